// File: rtl/grant_decoder_2_4_if.sv
// Handshake bundle between the priority encoder/clients and grant_decoder_2_4.
// The master side drives the request and release signals and watches the grant.
interface grant_decoder_2_4_if;
    logic [1:0] code;
    logic       dis;
    logic [3:0] done;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    modport master (
        output code, dis, done,
        input  grant, owner, busy, timeout
    );

    modport slave (
        input  code, dis, done,
        output grant, owner, busy, timeout
    );
endinterface

// File: rtl/grant_decoder_2_4.sv
// Sequential 2-to-4 grant decoder with a registered one-hot grant and a dead GAP cycle.
// Define TIMEOUT_EN to revoke a grant after TIMEOUT_CYCLES cycles.
module grant_decoder_2_4 #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 4
) (
    input  logic           clk,
    input  logic           rst,
    grant_decoder_2_4_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

`ifdef TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    state_e           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       owner_q, owner_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // code is only looked at when dis is low, so X on code cannot leak.
                if (!bus.dis) begin
                    owner_d = bus.code;
                    grant_d = 4'b0001 << bus.code;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (bus.done[owner_q]) begin
                    grant_d = '0;
                    state_d = GAP;
                end
`ifdef TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = GAP;
                end
`endif
                else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_grant_decoder_2_4.sv
// Directed self-checking bench for grant_decoder_2_4; outputs sampled 1 time unit after each rising edge.
module tb_grant_decoder_2_4;

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    grant_decoder_2_4_if bus ();

    grant_decoder_2_4 #(
        .TIMEOUT_CYCLES (15),
        .CNT_W          (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    initial begin
        rst      = 1'b1;
        bus.dis  = 1'b1;
        bus.code = 2'b00;
        bus.done = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        check("rst_grant",   bus.grant,   4'b0000);
        check("rst_owner",   bus.owner,   4'd0);
        check("rst_busy",    bus.busy,    4'd0);
        check("rst_timeout", bus.timeout, 4'd0);

        // Basic grant and release on index 2.
        bus.dis  = 1'b0;
        bus.code = 2'b10;
        tick();
        check("basic_grant", bus.grant, 4'b0100);
        check("basic_owner", bus.owner, 4'd2);
        check("basic_busy",  bus.busy,  4'd1);
        bus.dis = 1'b1;
        tick();
        tick();
        check("basic_hold", bus.grant, 4'b0100);
        bus.done = 4'b0100;
        tick();
        check("basic_rel_grant", bus.grant, 4'b0000);
        check("basic_rel_busy",  bus.busy,  4'd1);
        bus.done = 4'b0000;
        tick();
        check("basic_idle_busy",  bus.busy,  4'd0);
        check("basic_owner_kept", bus.owner, 4'd2);

        // Reset in the middle of a grant.
        bus.dis  = 1'b0;
        bus.code = 2'b10;
        tick();
        check("mid_pre_grant", bus.grant, 4'b0100);
        bus.dis = 1'b1;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_grant", bus.grant, 4'b0000);
        check("mid_rst_busy",  bus.busy,  4'd0);
        check("mid_rst_owner", bus.owner, 4'd0);
        bus.dis  = 1'b0;
        bus.code = 2'b01;
        tick();
        check("mid_rst_idle_regrant", bus.grant, 4'b0010);
        bus.dis  = 1'b1;
        bus.done = 4'b0010;
        tick();
        bus.done = 4'b0000;
        tick();
        check("mid_rst_back_idle", bus.busy, 4'd0);

        // Non-owner done bits and code changes are ignored during a grant.
        bus.dis  = 1'b0;
        bus.code = 2'b00;
        tick();
        check("ign_grant", bus.grant, 4'b0001);
        bus.code = 2'b11;
        bus.done = 4'b1110;
        tick();
        check("ign_hold1", bus.grant, 4'b0001);
        check("ign_owner", bus.owner, 4'd0);
        tick();
        check("ign_hold2", bus.grant, 4'b0001);
        bus.dis  = 1'b1;
        bus.done = 4'b0001;
        tick();
        check("ign_release", bus.grant, 4'b0000);
        bus.done = 4'b0000;
        tick();
        check("ign_idle", bus.busy, 4'd0);

        // Disabled encoder with an unknown code.
        bus.dis  = 1'b1;
        bus.code = 2'bxx;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("dis_grant", bus.grant, 4'b0000);
            check("dis_busy",  bus.busy,  4'd0);
            check("dis_no_x",  {3'b000, $isunknown({bus.grant, bus.owner, bus.busy, bus.timeout})}, 4'd0);
        end

        // Back-to-back requests on index 3 with a release pulse.
        bus.dis  = 1'b0;
        bus.code = 2'b11;
        tick();
        check("b2b_grant1", bus.grant, 4'b1000);
        bus.done = 4'b1000;
        tick();
        check("b2b_rel",      bus.grant, 4'b0000);
        check("b2b_gap_busy", bus.busy,  4'd1);
        bus.done = 4'b0000;
        tick();
        check("b2b_idle_grant", bus.grant, 4'b0000);
        check("b2b_idle_busy",  bus.busy,  4'd0);
        tick();
        check("b2b_regrant", bus.grant, 4'b1000);
        check("b2b_owner",   bus.owner, 4'd3);
        bus.dis  = 1'b1;
        bus.done = 4'b1000;
        tick();
        bus.done = 4'b0000;
        tick();
        check("b2b_done_idle", bus.busy, 4'd0);

`ifdef TIMEOUT_EN
        // Grant on index 1 with no release: revoked after exactly 15 cycles.
        bus.dis  = 1'b0;
        bus.code = 2'b01;
        tick();
        bus.dis = 1'b1;
        check("to_grant", bus.grant, 4'b0010);
        for (int i = 1; i < 15; i++) begin
            tick();
            check("to_hold",      bus.grant,   4'b0010);
            check("to_no_pulse",  bus.timeout, 4'd0);
        end
        tick();
        check("to_revoke_grant", bus.grant,   4'b0000);
        check("to_pulse",        bus.timeout, 4'd1);
        tick();
        check("to_pulse_end", bus.timeout, 4'd0);
        check("to_idle",      bus.busy,    4'd0);

        // done on the expiry edge wins over the timeout.
        bus.dis  = 1'b0;
        bus.code = 2'b01;
        tick();
        bus.dis = 1'b1;
        for (int i = 1; i < 15; i++) tick();
        check("tod_hold_last", bus.grant, 4'b0010);
        bus.done = 4'b0010;
        tick();
        bus.done = 4'b0000;
        check("tod_release",  bus.grant,   4'b0000);
        check("tod_no_pulse", bus.timeout, 4'd0);
        tick();
        check("tod_gap_no_pulse", bus.timeout, 4'd0);
        check("tod_idle",         bus.busy,    4'd0);
`else
        // Without the timeout a grant is held indefinitely and timeout never pulses.
        bus.dis  = 1'b0;
        bus.code = 2'b01;
        tick();
        bus.dis = 1'b1;
        check("long_grant", bus.grant, 4'b0010);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("long_hold",    bus.grant,   4'b0010);
            check("long_timeout", bus.timeout, 4'd0);
        end
        bus.done = 4'b0010;
        tick();
        bus.done = 4'b0000;
        check("long_release",    bus.grant,   4'b0000);
        check("long_rel_timeout", bus.timeout, 4'd0);
        tick();
        check("long_idle", bus.busy, 4'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/grant_decoder_2_4.md
# grant_decoder_2_4

- Sequential 2-to-4 grant decoder; the consumer side of the 4x2 priority encoder.
- Takes the encoder's 2-bit winning index and its disable flag, and drives a registered one-hot grant to the winning requester.
- Holds the grant until that requester releases it.
- Inserts one dead cycle between grants, so two grants can never overlap.
- Sits between the request priority encoder and the four shared-resource clients.

## Interface
Parameters:
- TIMEOUT_CYCLES, 15, maximum grant length in cycles when the timeout is compiled in; legal range 1 .. 2^CNT_W-1.
- CNT_W, 4, width of the grant-length counter.

Ports:
- clk  in  1  single clock; everything updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- code  in  2  winning index from the priority encoder.
- dis  in  1  encoder disable; 1 = no request pending, and `code` is don't-care (may be X).
- done  in  4  per-client release; only bit [owner] is honoured.
- grant  out  4  registered one-hot grant; 4'b0000 when no grant is active.
- owner  out  2  index of the current or last grantee.
- busy  out  1  high in the GRANT and GAP states.
- timeout  out  1  one-cycle pulse when a grant is revoked by the timeout.

## Operation
- Reset (sampled at an edge with rst=1):
  - grant=4'b0000, owner=2'b00, busy=0, timeout=0, counter=0, state=IDLE.
  - rst overrides every other input, including mid-grant.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If dis=0: owner<=code, grant<=4'b0001<<code, counter<=0, go to GRANT.
  - If dis=1: stay in IDLE; `code` is ignored, even if it is X or Z.
- GRANT:
  - If done[owner]=1: grant<=0, go to GAP.
  - Else if TIMEOUT_EN is defined and counter==TIMEOUT_CYCLES-1: grant<=0, timeout<=1, go to GAP.
  - Else: counter<=counter+1, and the grant is held.
  - Changes on `code` and `dis` are ignored in this state; there is no preemption.
  - done bits for non-owners are ignored.
- GAP:
  - grant=0 and timeout<=0, then go to IDLE unconditionally.
  - Requests present during GAP are not sampled.
- Simultaneous done[owner] and timeout expiry: done wins, and no timeout pulse is issued.
- Counter: unsigned, CNT_W bits, cleared on entry to GRANT. It never wraps, because expiry occurs first when the timeout is enabled. Without TIMEOUT_EN it saturates at 2^CNT_W-1.
- owner holds its value after release until the next grant.
- Invariants:
  - grant is always 0 or exactly one-hot.
  - grant!=0 implies busy=1.

## Timing
- Grant latency: a request sampled at edge k in IDLE gives grant valid after edge k, i.e. 1 cycle.
- Release: done[owner] sampled at edge m gives grant=0 after m and busy=0 after m+1. The earliest new request is sampled at edge m+2 and granted after m+2.
- Minimum grant length: 1 cycle, when done[owner] is already high at the first GRANT edge.
- Grant-to-grant spacing: at least 3 edges (GRANT, GAP, IDLE sample).
- Timeout: grant is high for exactly TIMEOUT_CYCLES cycles. The timeout pulse is high for the single cycle after the revoking edge, aligned with the first GAP cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- TIMEOUT_EN defined:
  - The grant-length timeout is active as described above.
  - The timeout output pulses on revocation.
- TIMEOUT_EN undefined:
  - A grant is held until done[owner], with no limit.
  - timeout is tied to 0.
  - The counter is still present but has no effect on grant.

## Test plan
- Reset mid-grant: grant=4'b0100 active, assert rst for 1 edge. Require grant=0, busy=0, owner=0, and state IDLE after that edge.
- Basic grant and release: dis=0, code=2'b10 at edge 1. Require grant=4'b0100, owner=2 after edge 1. Drive done=4'b0100 at edge 4. Require grant=0 after edge 4 and busy=0 after edge 5.
- Ignored inputs: during grant=4'b0001, drive done=4'b1110 and code=2'b11. Require the grant to be held and owner=0. Then done=4'b0001 releases it.
- Disable handling: dis=1 with code=2'bxx for 5 cycles. Require grant=0 and busy=0 throughout, with no X on any output.
- Back-to-back requests: dis=0, code=3 held continuously with done[3] pulsed at edge 2. Require grant=4'b1000 after edges 1–2 and 0 after edges 2–3. Require re-grant of 4'b1000 after edge 4.
- Timeout (TIMEOUT_EN, TIMEOUT_CYCLES=15): grant code=1 with no done. Require grant=4'b0010 for exactly 15 cycles, then timeout=1 for 1 cycle with grant=0. A repeat run with done[1] on the expiry edge must show no timeout pulse.
